hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM encoding, forward-select codes and the forwarding priority rule.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TIMEOUT  = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int DEFAULT_WAIT_LIMIT = 255;

  // EX/MEM holds the younger result, so it wins when both stages match.
  function automatic logic [1:0] fwd_select(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    logic [1:0] sel;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count up on inc and hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch/jump
// redirect, load-use bubble, operand forwarding and stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_RegWrite,
  input  logic             ex_MemRead,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             mem_Branch,
  input  logic             mem_branchAlu,
  input  logic             mem_Jump,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  hz_state_e         state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;

  logic mem_access_s;
  logic freeze_raw_s;
  logic freeze_s;
  logic redirect_s;
  logic hazard_s;
  logic load_use_s;

  assign mem_access_s = mem_MemRead | mem_MemWrite;

  // Freeze request as a function of FSM state and the live memory handshake.
  always_comb begin
    freeze_raw_s = 1'b0;
    case (state_r)
      ST_RUN:      freeze_raw_s = mem_access_s & ~dmem_ready;
      ST_MEM_WAIT: freeze_raw_s = ~dmem_ready;
      ST_TIMEOUT:  freeze_raw_s = 1'b1;
      default:     freeze_raw_s = 1'b1;
    endcase
  end

  // Reset forces the normal pass-through pattern, so a pending wait leaves no residue.
  assign freeze_s   = reset_n & freeze_raw_s;
  assign redirect_s = reset_n & ~freeze_s & (mem_Jump | (mem_Branch & mem_branchAlu));
  assign hazard_s   = ex_MemRead & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign load_use_s = reset_n & ~freeze_s & ~redirect_s & hazard_s;

  // Stage enables and flushes, priority freeze > redirect > load-use > normal.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    if (freeze_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect_s) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      pc_redirect = 1'b0;
    end
  end

  // Memory-wait FSM with bounded wait and sticky timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= '0;
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          wait_cnt_r <= '0;
          if (mem_access_s && !dmem_ready) begin
            state_r <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r       <= ST_TIMEOUT;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_TIMEOUT: begin
          wait_cnt_r    <= '0;
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r       <= ST_TIMEOUT;
          wait_cnt_r    <= '0;
          mem_timeout_r <= 1'b1;
        end
      endcase
    end
  end

  assign mem_timeout = mem_timeout_r;

  assign fwd_a = fwd_select(mem_RegWrite, mem_rd, wb_RegWrite, wb_rd, id_rs1);
  assign fwd_b = fwd_select(mem_RegWrite, mem_rd, wb_RegWrite, wb_rd, id_rs2);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (freeze_s | load_use_s),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset_n),
    .inc   (redirect_s),
    .count (flush_cnt)
  );

  logic unused_s;
  assign unused_s = ex_RegWrite;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a rule-level model.
module tb_hazard_ctrl;

  localparam int WL   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_RegWrite, ex_MemRead;
  logic mem_RegWrite, mem_MemRead, mem_MemWrite, mem_Branch, mem_branchAlu, mem_Jump;
  logic wb_RegWrite, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect;
  logic [1:0] fwd_a, fwd_b;
  logic mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0] ctrl_vec;

  int checks = 0;
  int failures = 0;

  bit m_pending, m_timed_out, e_frz, e_redir, e_lu;
  int m_waited, m_stall, m_flush;
  logic [9:0] e_ctrl;

  hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch), .mem_branchAlu(mem_branchAlu),
    .mem_Jump(mem_Jump), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_redirect(pc_redirect),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_RegWrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_eval();
    if (!reset_n) begin
      m_pending = 1'b0; m_timed_out = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
    end
    e_frz   = reset_n && (m_timed_out || (!dmem_ready && (m_pending || mem_MemRead || mem_MemWrite)));
    e_redir = reset_n && !e_frz && (mem_Jump || (mem_Branch && mem_branchAlu));
    e_lu    = reset_n && !e_frz && !e_redir && ex_MemRead && ex_rd != 5'd0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (e_frz)        e_ctrl = 10'b00000_00010;
    else if (e_redir) e_ctrl = 10'b11111_11101;
    else if (e_lu)    e_ctrl = 10'b00111_01000;
    else              e_ctrl = 10'b11111_00000;
  endtask

  task automatic model_update();
    if (reset_n) begin
      if (e_frz || e_lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (e_redir)       m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (m_timed_out) begin
        m_timed_out = 1'b1;
      end else if (m_pending) begin
        if (dmem_ready) begin
          m_pending = 1'b0; m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited == WL) begin m_timed_out = 1'b1; m_pending = 1'b0; end
        end
      end else if ((mem_MemRead || mem_MemWrite) && !dmem_ready) begin
        m_pending = 1'b1; m_waited = 0;
      end
    end
  endtask

  // Check one cycle against the model, then advance to the next falling edge.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ":ctrl"}, 32'(ctrl_vec), 32'(e_ctrl));
    chk({tag, ":fwd_a"}, 32'(fwd_a), 32'(ref_fwd(id_rs1)));
    chk({tag, ":fwd_b"}, 32'(fwd_b), 32'(ref_fwd(id_rs2)));
    chk({tag, ":timeout"}, 32'(mem_timeout), 32'(m_timed_out));
    chk({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ":flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_RegWrite = 1'b0; ex_MemRead = 1'b0;
    mem_rd = 5'd0; mem_RegWrite = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    mem_Branch = 1'b0; mem_branchAlu = 1'b0; mem_Jump = 1'b0;
    wb_rd = 5'd0; wb_RegWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step("rst");
    reset_n = 1'b1;
  endtask

  task automatic rand_inputs(input int ready_den);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    ex_rd = 5'($urandom_range(0, 3)); ex_RegWrite = 1'($urandom);
    ex_MemRead = 1'($urandom);
    mem_rd = 5'($urandom_range(0, 3)); mem_RegWrite = 1'($urandom);
    mem_MemRead = ($urandom_range(0, 3) == 0); mem_MemWrite = ($urandom_range(0, 3) == 0);
    mem_Branch = ($urandom_range(0, 3) == 0); mem_branchAlu = 1'($urandom);
    mem_Jump = ($urandom_range(0, 5) == 0);
    wb_rd = 5'($urandom_range(0, 3)); wb_RegWrite = 1'($urandom);
    dmem_ready = ($urandom_range(0, ready_den - 1) != 0);
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    mem_MemRead = 1'b1; dmem_ready = 1'b0; mem_Jump = 1'b1;
    ex_MemRead = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2; id_use_rs1 = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_pc_en", 32'(pc_en), 32'd1);
    chk("reset_mem_wb_flush", 32'(mem_wb_flush), 32'd0);
    step("reset");
    step("reset");
    clear_inputs();
    reset_n = 1'b1;
    step("idle");

    // Load-use: single bubble, then the load moves on.
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    chk("lu_pc_en", 32'(pc_en), 32'd0);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
    chk("lu_stall_before", 32'(stall_cnt), 32'd0);
    step("loaduse");
    chk("lu_stall_after", 32'(stall_cnt), 32'd1);
    clear_inputs();
    step("lu_advance");

    // Forwarding priority and x0 handling.
    mem_rd = 5'd3; wb_rd = 5'd3; mem_RegWrite = 1'b1; wb_RegWrite = 1'b1; id_rs2 = 5'd3;
    #1; chk("fwd_b_mem", 32'(fwd_b), 32'd1);
    step("fwd_mem");
    mem_rd = 5'd0;
    #1; chk("fwd_b_wb", 32'(fwd_b), 32'd2);
    step("fwd_wb");
    wb_rd = 5'd0; id_rs2 = 5'd0;
    #1; chk("fwd_b_rf", 32'(fwd_b), 32'd0);
    step("fwd_rf");
    clear_inputs();

    // Redirect beats a simultaneous load-use.
    mem_Branch = 1'b1; mem_branchAlu = 1'b1;
    ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    #1;
    chk("redir_pc_redirect", 32'(pc_redirect), 32'd1);
    chk("redir_pc_en", 32'(pc_en), 32'd1);
    chk("redir_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd7);
    step("redirect");
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    clear_inputs();

    // Four-cycle memory wait.
    pulse_reset();
    mem_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; chk("wait_mem_wb_flush", 32'(mem_wb_flush), 32'd1);
      step("memwait");
    end
    dmem_ready = 1'b1;
    #1; chk("wait_release_pc_en", 32'(pc_en), 32'd1);
    step("release");
    clear_inputs();
    step("after_wait");
    chk("wait_stall_cnt", 32'(stall_cnt), 32'd4);

    // Reset in the middle of a wait drops the freeze at once.
    mem_MemWrite = 1'b1; dmem_ready = 1'b0;
    step("wait_a"); step("wait_b");
    reset_n = 1'b0;
    #1; chk("midwait_reset_pc_en", 32'(pc_en), 32'd1);
    step("midwait_rst");
    reset_n = 1'b1; clear_inputs();
    step("post_rst");

    // Timeout after WL cycles in the wait state, sticky until reset.
    mem_MemRead = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < WL; i++) step("to_wait");
    chk("to_not_yet", 32'(mem_timeout), 32'd0);
    step("to_last");
    chk("to_set", 32'(mem_timeout), 32'd1);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1; chk("to_freeze_held", 32'(pc_en), 32'd0);
      step("to_hold");
    end
    pulse_reset();
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    chk("to_stall_cleared", 32'(stall_cnt), 32'd0);
    step("to_run");

    // Stall counter saturates.
    ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    clear_inputs();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);

    // Randomized blocks, each started from reset.
    for (int blk = 0; blk < 6; blk++) begin
      pulse_reset();
      for (int c = 0; c < 60; c++) begin
        rand_inputs((blk == 5) ? 8 : 3);
        if (blk == 5 && c < 12) dmem_ready = 1'b0;
        step("random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
